// File: rtl/bist_scheduler.sv
// Round-robin scheduler that shares one BIST controller among NCORES cores,
// runs the START/FINISH handshake and records per-core pass/fail with a watchdog.
module bist_scheduler #(
   parameter int NCORES  = 4,
   parameter int SIG_W   = 16,
   parameter int TIMEOUT = 127,
   parameter int CNT_W   = 8
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [NCORES-1:0]       REQ,
   input  logic [NCORES*SIG_W-1:0] GOLDEN,
   input  logic [SIG_W-1:0]        SIG,
   input  logic                    BIST_FINISH,
   input  logic                    BIST_END,
   output logic                    BIST_START,
   output logic [NCORES-1:0]       GRANT,
   output logic                    BUSY,
   output logic [NCORES-1:0]       DONE,
   output logic [NCORES-1:0]       PASS,
   output logic                    TIMEOUT_ERR
);

   localparam int PTR_W = (NCORES > 1) ? $clog2(NCORES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_ARM, S_RUN, S_CHECK, S_FAULT, S_GAP
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [CNT_W-1:0]   cnt;
   logic               gap_cnt;
   logic [SIG_W-1:0]   sig_p1;
   logic [NCORES-1:0]  elig;
   logic [PTR_W-1:0]   sel_idx;
   logic [SIG_W-1:0]   golden_g;
   logic               bist_end_unused;

   // BIST_END is observed by the controller-side handshake only; no state depends on it.
   assign bist_end_unused = BIST_END;

   assign elig     = REQ & ~DONE;
   assign golden_g = GOLDEN[ptr*SIG_W +: SIG_W];
   assign sel_idx  = next_idx(elig, ptr);

   function automatic logic [PTR_W-1:0] next_idx(input logic [NCORES-1:0] e,
                                                 input logic [PTR_W-1:0]  p);
      logic [PTR_W-1:0] r;
      logic             found;
      int               k;
      r     = p;
      found = 1'b0;
      for (int i = 1; i <= NCORES; i++) begin
         k = (int'(p) + i) % NCORES;
         if (!found && e[k]) begin
            r     = PTR_W'(k);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= S_IDLE;
         ptr         <= PTR_W'(NCORES - 1);
         cnt         <= '0;
         gap_cnt     <= 1'b0;
         BIST_START  <= 1'b0;
         GRANT       <= '0;
         BUSY        <= 1'b0;
         DONE        <= '0;
         PASS        <= '0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         // A dropped request withdraws its result on the next edge.
         DONE <= DONE & REQ;
         PASS <= PASS & REQ;
         case (state)
            S_IDLE: begin
               if (elig != '0) begin
                  state <= S_SEL;
                  BUSY  <= 1'b1;
               end
            end
            S_SEL: begin
               if (elig == '0) begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end else begin
                  ptr   <= sel_idx;
                  GRANT <= NCORES'(1) << sel_idx;
                  state <= S_ARM;
               end
            end
            S_ARM: begin
               BIST_START <= 1'b1;
               cnt        <= '0;
               state      <= S_RUN;
            end
            S_RUN: begin
               if (BIST_FINISH) begin
                  state <= S_CHECK;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  state <= S_FAULT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_CHECK: begin
               DONE[ptr]  <= REQ[ptr];
               PASS[ptr]  <= REQ[ptr] && (sig_p1 == golden_g);
               BIST_START <= 1'b0;
               gap_cnt    <= 1'b0;
               state      <= S_GAP;
            end
            S_FAULT: begin
               DONE[ptr]   <= REQ[ptr];
               PASS[ptr]   <= 1'b0;
               TIMEOUT_ERR <= 1'b1;
               BIST_START  <= 1'b0;
               gap_cnt     <= 1'b0;
               state       <= S_GAP;
            end
            S_GAP: begin
               cnt <= '0;
               if (gap_cnt) begin
                  GRANT <= '0;
                  BUSY  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

   // Signature capture stage: data only, no reset needed.
   always_ff @(posedge CLK) begin
      if (state == S_RUN && BIST_FINISH) sig_p1 <= SIG;
   end

endmodule

// File: tb/tb_bist_scheduler.sv
// Directed testbench for bist_scheduler: latency, round-robin order, pass/fail,
// watchdog, asynchronous reset and request withdrawal.
module tb_bist_scheduler;

   logic        CLK;
   logic        RESET;
   logic [3:0]  REQ;
   logic [63:0] GOLDEN;
   logic [15:0] SIG;
   logic        BIST_FINISH;
   logic        BIST_END;
   logic        BIST_START;
   logic [3:0]  GRANT;
   logic        BUSY;
   logic [3:0]  DONE;
   logic [3:0]  PASS;
   logic        TIMEOUT_ERR;

   int checks = 0;
   int errors = 0;

   bist_scheduler #(.NCORES(4), .SIG_W(16), .TIMEOUT(127), .CNT_W(8)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .GOLDEN(GOLDEN), .SIG(SIG),
      .BIST_FINISH(BIST_FINISH), .BIST_END(BIST_END), .BIST_START(BIST_START),
      .GRANT(GRANT), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic apply_reset();
      RESET       = 1'b1;
      REQ         = '0;
      SIG         = '0;
      BIST_FINISH = 1'b0;
      BIST_END    = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   task automatic wait_grant(output logic [3:0] g, output bit ok);
      ok = 1'b0;
      g  = '0;
      for (int i = 0; i < 20; i++) begin
         if (GRANT != '0) begin
            ok = 1'b1;
            g  = GRANT;
            break;
         end
         @(negedge CLK);
      end
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (BIST_START) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      REQ = '0; SIG = '0; BIST_FINISH = 1'b0; BIST_END = 1'b0;
      @(negedge CLK);
      checks++;
      if ({BIST_START, GRANT, BUSY, DONE, PASS, TIMEOUT_ERR} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0",
                  {BIST_START, GRANT, BUSY, DONE, PASS, TIMEOUT_ERR});
      end
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || GRANT !== 4'b0000) begin
         errors++;
         $display("FAIL idle_no_req: busy=%b grant=%b required 0/0000", BUSY, GRANT);
      end
   endtask

   task automatic test_single_core();
      REQ = 4'b0100;
      @(negedge CLK);
      checks++;
      if (GRANT !== 4'b0000) begin
         errors++; $display("FAIL t1_grant_c1: got %b required 0000", GRANT);
      end
      BIST_END = 1'b1;
      @(negedge CLK);
      checks++;
      if (GRANT !== 4'b0100 || BIST_START !== 1'b0) begin
         errors++; $display("FAIL t1_grant_c2: grant=%b start=%b required 0100/0", GRANT, BIST_START);
      end
      @(negedge CLK);
      BIST_END = 1'b0;
      checks++;
      if (BIST_START !== 1'b1 || BUSY !== 1'b1) begin
         errors++; $display("FAIL t1_start_c3: start=%b busy=%b required 1/1", BIST_START, BUSY);
      end
      SIG = 16'hA5C3; BIST_FINISH = 1'b1;
      @(negedge CLK);
      BIST_FINISH = 1'b0; SIG = '0;
      checks++;
      if (DONE !== 4'b0000) begin
         errors++; $display("FAIL t1_done_early: got %b required 0000", DONE);
      end
      @(negedge CLK);
      checks++;
      if (DONE !== 4'b0100 || PASS !== 4'b0100 || BIST_START !== 1'b0) begin
         errors++; $display("FAIL t1_result: done=%b pass=%b start=%b required 0100/0100/0", DONE, PASS, BIST_START);
      end
      @(negedge CLK);
      checks++;
      if (GRANT !== 4'b0100 || BUSY !== 1'b1) begin
         errors++; $display("FAIL t1_gap_hold: grant=%b busy=%b required 0100/1", GRANT, BUSY);
      end
      @(negedge CLK);
      checks++;
      if (GRANT !== 4'b0000 || BUSY !== 1'b0) begin
         errors++; $display("FAIL t1_gap_exit: grant=%b busy=%b required 0000/0", GRANT, BUSY);
      end
      repeat (5) @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || DONE !== 4'b0100) begin
         errors++; $display("FAIL t1_no_regrant: busy=%b done=%b required 0/0100", BUSY, DONE);
      end
      REQ = 4'b0000;
      @(negedge CLK);
      checks++;
      if (DONE !== 4'b0000 || PASS !== 4'b0000) begin
         errors++; $display("FAIL t1_req_drop_clear: done=%b pass=%b required 0000/0000", DONE, PASS);
      end
   endtask

   task automatic test_round_robin();
      logic [15:0] sig_tab [4];
      logic [3:0]  g;
      logic [3:0]  exp_g;
      bit          ok;
      sig_tab[0] = 16'h1111; sig_tab[1] = 16'h1234; sig_tab[2] = 16'hA5C3; sig_tab[3] = 16'h4444;
      apply_reset();
      REQ = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         exp_g = 4'b0001 << i;
         wait_grant(g, ok);
         checks++;
         if (!ok || g !== exp_g) begin
            errors++; $display("FAIL t2_grant_order[%0d]: got %b required %b", i, g, exp_g);
         end
         wait_start(ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL t2_start[%0d]: start=%b required 1", i, BIST_START);
         end
         SIG = sig_tab[i]; BIST_FINISH = 1'b1;
         @(negedge CLK);
         BIST_FINISH = 1'b0;
         @(negedge CLK);
         checks++;
         if (BIST_START !== 1'b0 || DONE[i] !== 1'b1) begin
            errors++; $display("FAIL t2_gap[%0d]: start=%b done=%b required 0/1", i, BIST_START, DONE);
         end
         @(negedge CLK);
         checks++;
         if (BIST_START !== 1'b0 || GRANT !== exp_g) begin
            errors++; $display("FAIL t2_gap2[%0d]: start=%b grant=%b required 0/%b", i, BIST_START, GRANT, exp_g);
         end
         @(negedge CLK);
      end
      checks++;
      if (DONE !== 4'b1111 || PASS !== 4'b1111) begin
         errors++; $display("FAIL t2_final: done=%b pass=%b required 1111/1111", DONE, PASS);
      end
   endtask

   task automatic test_mismatch();
      logic [3:0] g;
      bit         ok;
      apply_reset();
      REQ = 4'b0010;
      wait_grant(g, ok);
      wait_start(ok);
      checks++;
      if (!ok || g !== 4'b0010) begin
         errors++; $display("FAIL t3_grant: got %b required 0010", g);
      end
      SIG = 16'h0000; BIST_FINISH = 1'b1;
      @(negedge CLK);
      BIST_FINISH = 1'b0;
      @(negedge CLK);
      checks++;
      if (DONE !== 4'b0010 || PASS !== 4'b0000 || TIMEOUT_ERR !== 1'b0) begin
         errors++; $display("FAIL t3_mismatch: done=%b pass=%b terr=%b required 0010/0000/0", DONE, PASS, TIMEOUT_ERR);
      end
   endtask

   task automatic test_timeout();
      logic [3:0] g;
      bit         ok;
      apply_reset();
      REQ = 4'b0001;
      wait_grant(g, ok);
      wait_start(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL t4_start: start=%b required 1", BIST_START);
      end
      repeat (128) @(negedge CLK);
      checks++;
      if (TIMEOUT_ERR !== 1'b0 || DONE !== 4'b0000) begin
         errors++; $display("FAIL t4_early_fault: terr=%b done=%b required 0/0000", TIMEOUT_ERR, DONE);
      end
      @(negedge CLK);
      checks++;
      if (TIMEOUT_ERR !== 1'b1 || DONE !== 4'b0001 || PASS !== 4'b0000 || BIST_START !== 1'b0) begin
         errors++; $display("FAIL t4_fault: terr=%b done=%b pass=%b start=%b required 1/0001/0000/0",
                            TIMEOUT_ERR, DONE, PASS, BIST_START);
      end
      repeat (4) @(negedge CLK);
      checks++;
      if (TIMEOUT_ERR !== 1'b1 || BUSY !== 1'b0) begin
         errors++; $display("FAIL t4_sticky: terr=%b busy=%b required 1/0", TIMEOUT_ERR, BUSY);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [3:0] g;
      bit         ok;
      apply_reset();
      REQ = 4'b1000;
      wait_grant(g, ok);
      wait_start(ok);
      repeat (5) @(negedge CLK);
      #2 RESET = 1'b1;
      #1;
      checks++;
      if ({BIST_START, GRANT, BUSY, DONE, PASS, TIMEOUT_ERR} !== 15'd0) begin
         errors++; $display("FAIL t5_async_reset: got %h required 0",
                            {BIST_START, GRANT, BUSY, DONE, PASS, TIMEOUT_ERR});
      end
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (GRANT !== 4'b1000 || BIST_START !== 1'b0) begin
         errors++; $display("FAIL t5_regrant: grant=%b start=%b required 1000/0", GRANT, BIST_START);
      end
      @(negedge CLK);
      checks++;
      if (BIST_START !== 1'b1) begin
         errors++; $display("FAIL t5_start: got %b required 1", BIST_START);
      end
      SIG = 16'h4444; BIST_FINISH = 1'b1;
      @(negedge CLK);
      BIST_FINISH = 1'b0;
      @(negedge CLK);
      checks++;
      if (DONE !== 4'b1000 || PASS !== 4'b1000) begin
         errors++; $display("FAIL t5_result: done=%b pass=%b required 1000/1000", DONE, PASS);
      end
   endtask

   task automatic test_req_drop_and_coincident();
      logic [3:0] g;
      bit         ok;
      apply_reset();
      REQ = 4'b1100;
      wait_grant(g, ok);
      checks++;
      if (!ok || g !== 4'b0100) begin
         errors++; $display("FAIL t6_first_grant: got %b required 0100", g);
      end
      wait_start(ok);
      repeat (3) @(negedge CLK);
      REQ = 4'b1000;
      repeat (3) @(negedge CLK);
      SIG = 16'hA5C3; BIST_FINISH = 1'b1;
      @(negedge CLK);
      BIST_FINISH = 1'b0;
      @(negedge CLK);
      checks++;
      if (DONE !== 4'b0000 || PASS !== 4'b0000) begin
         errors++; $display("FAIL t6_dropped_no_done: done=%b pass=%b required 0000/0000", DONE, PASS);
      end
      wait_grant(g, ok);
      checks++;
      if (g !== 4'b0100) begin
         errors++; $display("FAIL t6_gap_hold: got %b required 0100", g);
      end
      @(negedge CLK);
      @(negedge CLK);
      wait_grant(g, ok);
      checks++;
      if (!ok || g !== 4'b1000) begin
         errors++; $display("FAIL t6_next_grant: got %b required 1000", g);
      end
      wait_start(ok);
      repeat (127) @(negedge CLK);
      SIG = 16'h4444; BIST_FINISH = 1'b1;
      @(negedge CLK);
      BIST_FINISH = 1'b0;
      @(negedge CLK);
      checks++;
      if (DONE !== 4'b1000 || PASS !== 4'b1000 || TIMEOUT_ERR !== 1'b0) begin
         errors++; $display("FAIL t6_coincident: done=%b pass=%b terr=%b required 1000/1000/0",
                            DONE, PASS, TIMEOUT_ERR);
      end
   endtask

   initial begin
      GOLDEN = {16'h4444, 16'hA5C3, 16'h1234, 16'h1111};
      test_reset();
      test_single_core();
      test_round_robin();
      test_mismatch();
      test_timeout();
      test_reset_mid_run();
      test_req_drop_and_coincident();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
